dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-requester arbiter and sequencer in front of the single-port data memory (256 x 32, combinational read, posedge write).
- Requester 0 is the pipeline MEM stage; requester 1 is the debug/loader port.
- Accepts one access at a time, drives the memory for exactly one cycle and returns a registered response.
- Fair round-robin arbitration when both ports request.

Parameters:
ADDR_W, 32, width of request and memory address.
DATA_W, 32, data width.
DEPTH, 256, number of memory words; addresses >= DEPTH are out of range.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
req  in  2  per-requester access request, held until granted.
we  in  2  per-requester write flag (1 = write, 0 = read).
addr0, addr1  in  ADDR_W  word address per requester.
wdata0, wdata1  in  DATA_W  write data per requester.
gnt  out  2  one-hot grant; request accepted at the rising edge where req[i] & gnt[i].
rsp_valid  out  2  one-cycle response pulse per requester.
rsp_data  out  DATA_W  read data, or 0 for writes and errors.
rsp_err  out  1  out-of-range flag, qualified by rsp_valid.
mem_we  out  1  memory write enable.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_rdata  in  DATA_W  memory combinational read data.

Behaviour:
- Reset values: state = IDLE; gnt, rsp_valid, rsp_err, mem_we = 0; rsp_data, mem_addr, mem_wdata = 0; last_grant = 1, so requester 0 wins the first tie.
- States:
  - IDLE: gnt is combinational from req and last_grant.
    - Single requester: it is granted.
    - Both requesting: grant the requester != last_grant.
    - On accept: latch id, we, addr and wdata; last_grant <= id; go to ACCESS.
  - ACCESS, one cycle:
    - gnt = 0; mem_addr and mem_wdata driven from the latched values.
    - mem_we = latched we & in_range; an out-of-range write is suppressed.
    - At the end of the cycle, capture rsp_data = in_range & ~we ? mem_rdata : 0, and rsp_err = ~in_range.
    - Go to RESP.
  - RESP, one cycle:
    - rsp_valid[id] = 1 for exactly this cycle.
    - gnt = 0; memory idle (mem_we = 0).
    - Go to IDLE.
- Latency: accept edge E0 -> memory cycle E0..E1 -> rsp_valid high E1..E2. Peak throughput is one access per 3 cycles.
- in_range = (addr < DEPTH), compared at full ADDR_W width, no truncation.
- Requests may be dropped or changed while not granted; nothing is latched until accept.
- Requester inputs are ignored outside IDLE.
- Reset asserted in ACCESS or RESP:
  - Immediate return to IDLE; mem_we drops asynchronously.
  - The pending response is lost, with no rsp_valid pulse.
- mem_* outputs hold their last values in IDLE and RESP; only mem_we is forced to 0 there.

Optional Feature:
DMEM_ARB_STATS_EN
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (16 bits each), counting accepts per requester.
  - Counters saturate at 0xFFFF and reset to 0.
  - Adds output err_cnt (8 bits, saturating), counting out-of-range accesses.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state enum typedef (IDLE, ACCESS, RESP);
  - the requester id typedef;
  - localparams REQ_CPU = 0 and REQ_DBG = 1.
- Sub-module rr_arb2: pure combinational two-way round-robin grant from (req, last_grant). State and latching stay in the top module.

Test Plan:
- Reset, then req = 01, write 0x0000_ABCD to addr 5 -> gnt = 01 in the same cycle; mem_we = 1 for one cycle with mem_addr = 5; rsp_valid = 01 two edges after accept; rsp_err = 0.
- Requester 1 reads addr 5 after the write above -> rsp_valid = 10; rsp_data = 0x0000_ABCD.
- Both request continuously from reset -> accept order 0, 1, 0, 1; no requester gets two consecutive grants; accepts spaced 3 cycles apart.
- Requester 0 writes addr 256 -> mem_we stays 0; rsp_err = 1; rsp_data = 0; memory word 0 unchanged.
- Reset pulse during the ACCESS cycle of a write -> mem_we falls immediately; no rsp_valid; next accept goes to requester 0 on a tie.
- With DMEM_ARB_STATS_EN: 3 accepts on port 0, 2 on port 1, 1 out-of-range -> grant_cnt0 = 3, grant_cnt1 = 2, err_cnt = 1.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and requester ids.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    typedef logic req_id_t;

    localparam req_id_t REQ_CPU = 1'b0;
    localparam req_id_t REQ_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant; on a tie the requester
// that did not win last time is granted.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_grant == REQ_CPU) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and sequencer for the single-port data memory.
// Optional accept/error statistics counters are built when DMEM_ARB_STATS_EN is defined.
//
// state  | meaning
// IDLE   | arbitrate, accept one request and latch it
// ACCESS | drive the memory for one cycle, capture the response
// RESP   | pulse rsp_valid for the accepted requester
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1,
    output logic [7:0]        err_cnt
`endif
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    arb_state_e        state;
    req_id_t           last_grant;
    req_id_t           cur_id;
    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;

    logic [1:0]        arb_gnt;
    logic              accept;
    req_id_t           acc_id;
    logic              in_range;

    rr_arb2 u_rr_arb2 (
        .req        (req),
        .last_grant (last_grant),
        .gnt        (arb_gnt)
    );

    assign gnt      = (state == IDLE) ? arb_gnt : 2'b00;
    assign accept   = |(req & gnt);
    assign acc_id   = req_id_t'(gnt[1]);
    assign in_range = (cur_addr < DEPTH_A);

    // mem_we is decoded from state so an async reset removes it immediately
    assign mem_we    = (state == ACCESS) & cur_we & in_range;
    assign mem_addr  = cur_addr;
    assign mem_wdata = cur_wdata;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= REQ_DBG;
            cur_id     <= REQ_CPU;
            cur_we     <= 1'b0;
            cur_addr   <= '0;
            cur_wdata  <= '0;
            rsp_valid  <= 2'b00;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 2'b00;
                    if (accept) begin
                        cur_id     <= acc_id;
                        cur_we     <= we[acc_id];
                        cur_addr   <= (acc_id == REQ_DBG) ? addr1 : addr0;
                        cur_wdata  <= (acc_id == REQ_DBG) ? wdata1 : wdata0;
                        last_grant <= acc_id;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    rsp_data  <= (in_range && !cur_we) ? mem_rdata : '0;
                    rsp_err   <= ~in_range;
                    rsp_valid <= (cur_id == REQ_DBG) ? 2'b10 : 2'b01;
                    state     <= RESP;
                end
                RESP: begin
                    rsp_valid <= 2'b00;
                    state     <= IDLE;
                end
                default: begin
                    rsp_valid <= 2'b00;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            err_cnt    <= '0;
        end else begin
            if (accept && acc_id == REQ_CPU && grant_cnt0 != 16'hFFFF) begin
                grant_cnt0 <= grant_cnt0 + 16'd1;
            end
            if (accept && acc_id == REQ_DBG && grant_cnt1 != 16'hFFFF) begin
                grant_cnt1 <= grant_cnt1 + 16'd1;
            end
            if (state == ACCESS && !in_range && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a 256x32 memory model.
// Define DMEM_ARB_STATS_EN to also check the statistics counters.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req   = 2'b00;
    logic [1:0]  we    = 2'b00;
    logic [31:0] addr0 = '0;
    logic [31:0] addr1 = '0;
    logic [31:0] wdata0 = '0;
    logic [31:0] wdata1 = '0;
    logic [1:0]  gnt;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;
    logic [7:0]  err_cnt;
`endif

    dmem_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clock = ~clock;

    // physical memory seen by the DUT
    logic [31:0] mem [256] = '{default: 32'h0};
    always @(posedge clock) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    assign mem_rdata = mem[mem_addr[7:0]];

    // reference memory, updated only from the scoreboard
    logic [31:0] ref_mem [256] = '{default: 32'h0};

    typedef struct {
        logic        id;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } pend_t;

    pend_t pend_q[$];
    logic  acc_id_q[$];
    int    acc_cyc_q[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_errors = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // scoreboard: push on accept, pop and compare on rsp_valid
    initial begin
        pend_t p;
        logic  inr;
        forever begin
            @(negedge clock or posedge reset);
            if (reset) begin
                pend_q.delete();
            end else begin
                check("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
                if (rsp_valid != 2'b00) begin
                    if (pend_q.size() == 0) begin
                        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                    end else begin
                        p   = pend_q.pop_front();
                        inr = (p.a < 32'd256);
                        check("rsp_valid", 32'(rsp_valid), p.id ? 32'd2 : 32'd1);
                        check("rsp_err", 32'(rsp_err), 32'(!inr));
                        check("rsp_data", rsp_data, (inr && !p.w) ? ref_mem[p.a[7:0]] : 32'd0);
                        if (inr && p.w) ref_mem[p.a[7:0]] = p.d;
                    end
                end
                if ((req & gnt) != 2'b00) begin
                    p.id = gnt[1];
                    p.w  = we[gnt[1]];
                    p.a  = gnt[1] ? addr1 : addr0;
                    p.d  = gnt[1] ? wdata1 : wdata0;
                    pend_q.push_back(p);
                    acc_id_q.push_back(gnt[1]);
                    acc_cyc_q.push_back(cyc);
                end
            end
        end
    end

    task automatic do_access(input logic id, input logic w, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        if (id) begin addr1 = a; wdata1 = d; end
        else begin addr0 = a; wdata0 = d; end
        we[id]  = w;
        req[id] = 1'b1;
        #1;
        while (!gnt[id] && n < 20) begin
            tick();
            n++;
        end
        check("gnt_wait", 32'(n < 20), 32'd1);
        check("gnt_value", 32'(gnt), id ? 32'd2 : 32'd1);
        tick();
        req[id] = 1'b0;
        check("mem_we", 32'(mem_we), 32'(w && a < 32'd256));
        check("mem_addr", mem_addr, a);
        if (w) check("mem_wdata", mem_wdata, d);
        tick();
        check("mem_we_resp", 32'(mem_we), 32'd0);
        check("rsp_pulse", 32'(rsp_valid), id ? 32'd2 : 32'd1);
        tick();
        check("rsp_done", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int base;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        tick();
        tick();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        tick();

        // write then read back from the other port
        do_access(1'b0, 1'b1, 32'd5, 32'h0000_ABCD);
        do_access(1'b1, 1'b0, 32'd5, 32'h0);

        // continuous contention from reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        base  = acc_id_q.size();
        req   = 2'b11;
        we    = 2'b00;
        addr0 = 32'd5;
        addr1 = 32'd6;
        repeat (11) tick();
        req = 2'b00;
        repeat (3) tick();
        check("rr_count", 32'(acc_id_q.size() - base), 32'd4);
        for (int i = 0; i < 4 && base + i < acc_id_q.size(); i++) begin
            check("rr_order", 32'(acc_id_q[base+i]), 32'(i % 2));
            if (i > 0) check("rr_spacing", 32'(acc_cyc_q[base+i] - acc_cyc_q[base+i-1]), 32'd3);
        end

        // out-of-range write leaves word 0 untouched
        do_access(1'b0, 1'b1, 32'd0, 32'h0000_1111);
        do_access(1'b0, 1'b1, 32'd256, 32'h0000_2222);
        check("mem0_kept", mem[0], 32'h0000_1111);
        do_access(1'b1, 1'b0, 32'd0, 32'h0);

        // reset in the middle of an ACCESS cycle
        addr0  = 32'd9;
        wdata0 = 32'h0000_5555;
        we     = 2'b01;
        req    = 2'b01;
        #1;
        check("abort_gnt", 32'(gnt), 32'd1);
        tick();
        req = 2'b00;
        check("abort_mem_we_on", 32'(mem_we), 32'd1);
        #1 reset = 1'b1;
        #1 check("abort_mem_we_off", 32'(mem_we), 32'd0);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        check("abort_mem9", mem[9], 32'd0);

        // tie after reset goes to requester 0; reads the unwritten word
        we    = 2'b00;
        addr1 = 32'd9;
        req   = 2'b11;
        #1;
        check("tie_after_reset", 32'(gnt), 32'd1);
        tick();
        req = 2'b00;
        tick();
        tick();
        check("tie_rsp_seen", 32'(pend_q.size()), 32'd0);

        // remaining accepts: port 0 total 3 (one out of range), port 1 total 2
        do_access(1'b0, 1'b0, 32'd300, 32'h0);
        do_access(1'b0, 1'b0, 32'd5, 32'h0);
        do_access(1'b1, 1'b1, 32'd7, 32'h0000_7777);
        do_access(1'b1, 1'b0, 32'd7, 32'h0);

`ifdef DMEM_ARB_STATS_EN
        check("grant_cnt0", 32'(grant_cnt0), 32'd3);
        check("grant_cnt1", 32'(grant_cnt1), 32'd2);
        check("err_cnt", 32'(err_cnt), 32'd1);
`endif
        check("sb_drained", 32'(pend_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
